// File: rtl/uart_receiver_if.sv
// Host-side bundle of the UART receiver: serial line, configuration, FIFO pop and status.
// Carries parity_error_o only when UART_RX_PARITY_EN is defined.
interface uart_receiver_if;
  logic       uart_rx_i;
  logic [1:0] baudrate_select_i;
  logic [5:0] data_buffer_full_thres_i;
  logic       data_read_i;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       data_buffer_full_o;
  logic       frame_error_o;
  logic       overrun_o;
`ifdef UART_RX_PARITY_EN
  logic       parity_error_o;

  modport slave (
    input  uart_rx_i, baudrate_select_i, data_buffer_full_thres_i, data_read_i,
    output data_o, data_valid_o, data_buffer_full_o, frame_error_o, overrun_o, parity_error_o
  );
  modport master (
    output uart_rx_i, baudrate_select_i, data_buffer_full_thres_i, data_read_i,
    input  data_o, data_valid_o, data_buffer_full_o, frame_error_o, overrun_o, parity_error_o
  );
`else
  modport slave (
    input  uart_rx_i, baudrate_select_i, data_buffer_full_thres_i, data_read_i,
    output data_o, data_valid_o, data_buffer_full_o, frame_error_o, overrun_o
  );
  modport master (
    output uart_rx_i, baudrate_select_i, data_buffer_full_thres_i, data_read_i,
    input  data_o, data_valid_o, data_buffer_full_o, frame_error_o, overrun_o
  );
`endif
endinterface

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled 8N1 (8E1 with UART_RX_PARITY_EN) into a 64-entry FWFT FIFO.
// Optional feature macro: UART_RX_PARITY_EN.
module uart_receiver #(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int FIFO_DEPTH  = 64
) (
  input logic       clock_i,
  input logic       reset_n_i,
  uart_receiver_if.slave bus
);

  function automatic int div_for(input int baud);
    return (CLK_FREQ_HZ + 8 * baud) / (16 * baud);
  endfunction

  localparam int DIV_9600   = div_for(9600);
  localparam int DIV_19200  = div_for(19200);
  localparam int DIV_57600  = div_for(57600);
  localparam int DIV_115200 = div_for(115200);
  localparam int DW = $clog2(DIV_9600 + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state_q, state_d;
  logic            rx_meta, rx_sync;
  logic [DW-1:0]   div_cnt, div_lat, div_sel;
  logic [3:0]      samp_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg;
  logic            tick, mid;
  logic            start_det, sample, push, fe_d, pe_d, drop;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, cnt_nxt;
  logic            do_push, do_pop, full_now, ovr_d;
  logic            frame_err_q, ovr_q, full_q;

  // Line is idle-high, so the synchroniser resets to 1 to avoid a false start.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= bus.uart_rx_i;
      rx_sync <= rx_meta;
    end
  end

  always_comb begin
    case (bus.baudrate_select_i)
      2'b00:   div_sel = DW'(DIV_9600);
      2'b01:   div_sel = DW'(DIV_19200);
      2'b10:   div_sel = DW'(DIV_57600);
      default: div_sel = DW'(DIV_115200);
    endcase
  end

  assign tick = (div_cnt == div_lat - DW'(1));
  // Sample counter is free-running mod 16: every mid-bit lands on count 7.
  assign mid  = tick && (samp_cnt == 4'd7);

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      div_cnt  <= '0;
      div_lat  <= DW'(DIV_9600);
      samp_cnt <= '0;
    end else if (start_det) begin
      div_cnt  <= '0;
      div_lat  <= div_sel;
      samp_cnt <= '0;
    end else if (tick) begin
      div_cnt  <= '0;
      samp_cnt <= samp_cnt + 4'd1;
    end else begin
      div_cnt  <= div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    start_det = 1'b0;
    sample    = 1'b0;
    push      = 1'b0;
    fe_d      = 1'b0;
    pe_d      = 1'b0;
    case (state_q)
      S_IDLE: if (!rx_sync) begin
        start_det = 1'b1;
        state_d   = S_START;
      end
      S_START: if (mid) state_d = rx_sync ? S_IDLE : S_DATA;
      S_DATA: if (mid) begin
        sample = 1'b1;
`ifdef UART_RX_PARITY_EN
        if (bit_cnt == 3'd7) state_d = S_PARITY;
`else
        if (bit_cnt == 3'd7) state_d = S_STOP;
`endif
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: if (mid) begin
        pe_d    = ^{shreg, rx_sync};
        state_d = S_STOP;
      end
`endif
      S_STOP: if (mid) begin
        if (rx_sync) begin
          push    = !drop;
          state_d = S_IDLE;
        end else begin
          fe_d    = 1'b1;
          state_d = S_BREAK;
        end
      end
      S_BREAK: if (rx_sync) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      bit_cnt <= '0;
      shreg   <= '0;
    end else if (start_det) begin
      bit_cnt <= '0;
    end else if (sample) begin
      shreg   <= {rx_sync, shreg[7:1]};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_err_q;

  // A bad parity still runs the stop check; the byte is just not pushed.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      drop      <= 1'b0;
      par_err_q <= 1'b0;
    end else begin
      par_err_q <= pe_d;
      if (start_det) drop <= 1'b0;
      else if (pe_d) drop <= 1'b1;
    end
  end

  assign bus.parity_error_o = par_err_q;
`else
  assign drop = 1'b0;
`endif

  assign full_now = (count == CW'(FIFO_DEPTH));
  assign do_pop   = bus.data_read_i && (count != '0);
  assign do_push  = push && (!full_now || do_pop);
  assign ovr_d    = push && full_now && !do_pop;

  always_comb begin
    cnt_nxt = count;
    if (do_push && !do_pop)      cnt_nxt = count + CW'(1);
    else if (!do_push && do_pop) cnt_nxt = count - CW'(1);
  end

  always_ff @(posedge clock_i) begin
    if (do_push) mem[wr_ptr] <= shreg;
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      full_q      <= 1'b0;
      frame_err_q <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count       <= cnt_nxt;
      full_q      <= (bus.data_buffer_full_thres_i == 6'd0) ? (cnt_nxt == CW'(FIFO_DEPTH))
                                                            : (cnt_nxt >= CW'(bus.data_buffer_full_thres_i));
      frame_err_q <= fe_d;
      ovr_q       <= ovr_d;
    end
  end

  assign bus.data_o             = (count != '0) ? mem[rd_ptr] : 8'h00;
  assign bus.data_valid_o       = (count != '0);
  assign bus.data_buffer_full_o = full_q;
  assign bus.frame_error_o      = frame_err_q;
  assign bus.overrun_o          = ovr_q;

endmodule
